// File: rtl/uart_pkg.sv
// uart_pkg: shared register addresses, IIR codes, LSR/LCR bit indices and the
// rx/tx frame state type for the uart_wb_modport UART.
package uart_pkg;

  // Register indices (wb_adr_i[2:0])
  localparam logic [2:0] AddrRbr = 3'd0;  // RBR/THR, DLL when DLAB=1
  localparam logic [2:0] AddrIer = 3'd1;  // IER, DLM when DLAB=1
  localparam logic [2:0] AddrIir = 3'd2;  // IIR read / FCR write
  localparam logic [2:0] AddrLcr = 3'd3;
  localparam logic [2:0] AddrMcr = 3'd4;
  localparam logic [2:0] AddrLsr = 3'd5;
  localparam logic [2:0] AddrMsr = 3'd6;
  localparam logic [2:0] AddrScr = 3'd7;

  // IIR[3:0] interrupt identification codes
  localparam logic [3:0] IirRls   = 4'h6;
  localparam logic [3:0] IirRda   = 4'h4;
  localparam logic [3:0] IirThre  = 4'h2;
  localparam logic [3:0] IirModem = 4'h0;
  localparam logic [3:0] IirNone  = 4'h1;

  // LSR bit indices
  localparam int unsigned LsrDr   = 0;
  localparam int unsigned LsrOe   = 1;
  localparam int unsigned LsrPe   = 2;
  localparam int unsigned LsrFe   = 3;
  localparam int unsigned LsrBi   = 4;
  localparam int unsigned LsrThre = 5;
  localparam int unsigned LsrTemt = 6;

  // LCR bit indices
  localparam int unsigned LcrStb   = 2;
  localparam int unsigned LcrPen   = 3;
  localparam int unsigned LcrEps   = 4;
  localparam int unsigned LcrStick = 5;
  localparam int unsigned LcrBreak = 6;
  localparam int unsigned LcrDlab  = 7;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Parity bit for the active word length in lcr[1:0]: odd, even or sticky.
  function automatic logic calc_parity(input logic [7:0] data, input logic [7:0] lcr);
    logic [7:0] mask;
    logic       par;
    mask = 8'hFF >> (2'd3 - lcr[1:0]);
    if (lcr[LcrStick]) begin
      par = ~lcr[LcrEps];
    end else if (lcr[LcrEps]) begin
      par = ^(data & mask);
    end else begin
      par = ~(^(data & mask));
    end
    return par;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divisor counter producing a one-clock 16x baud tick every
// divisor_i clocks; a zero divisor stops the ticks, reload_i restarts the count.
module uart_baud_gen (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] divisor_i,
  input  logic        reload_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;

  // Next count and tick; >= keeps the counter sane if the divisor shrinks.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (reload_i || (divisor_i == 16'd0)) begin
      cnt_d = '0;
    end else if (cnt_q >= (divisor_i - 16'd1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_wb_modport.sv
// uart_wb_modport: 16450-mode UART core behind a Wishbone classic slave port.
// Build macro UART_LOOPBACK_EN enables the MCR[4] internal loopback path.
module uart_wb_modport
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic [3:0]            wb_sel_i,
  output logic                  wb_ack_o,
  output logic                  int_o,
  input  logic                  srx_pad_i,
  output logic                  stx_pad_o,
  output logic                  rts_pad_o,
  output logic                  dtr_pad_o,
  input  logic                  cts_pad_i,
  input  logic                  dsr_pad_i,
  input  logic                  ri_pad_i,
  input  logic                  dcd_pad_i,
  output logic                  baud_o
);

  // Register file and status state
  logic       ack_q, int_q;
  logic [3:0] ier_q;
  logic [7:0] lcr_q, scr_q, dll_q, dlm_q, thr_q, rbr_q;
  logic [4:0] mcr_q;
  logic       thre_q, thre_d, thre_pend_q, thre_pend_d;
  logic       dr_q, oe_q, pe_q, fe_q, bi_q;
  logic [3:0] msr_hi_q, msr_hi_cur, msr_delta_q, msr_delta_set;
  logic [3:0] iir_code;
  logic [7:0] lsr, rdata;

  // Access decode
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       wr, rd, dlab, loop;
  logic       thr_wr, dl_wr, rbr_rd, iir_rd, lsr_rd, msr_rd;
  logic       unused_bits;

  // TX state
  uart_state_e tx_st_q, tx_st_d;
  logic [3:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_par_q, tx_par_d, tx_out_q, tx_out_d, tx_load;

  // RX state
  uart_state_e rx_st_q, rx_st_d;
  logic [3:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_par_q, rx_par_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_in;
  logic        rx_done, rx_pe, rx_fe, rx_bi;

  logic [2:0]  last_bit;

  assign addr        = wb_adr_i[2:0];
  assign wdata       = wb_dat_i[7:0];
  assign unused_bits = ^{wb_sel_i, wb_adr_i, wb_dat_i};
  assign dlab        = lcr_q[LcrDlab];
  assign last_bit    = {1'b0, lcr_q[1:0]} + 3'd4;

  // Side effects happen on the ack cycle only.
  assign wr     = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;
  assign rd     = ack_q & wb_cyc_i & wb_stb_i & ~wb_we_i;
  assign thr_wr = wr & (addr == AddrRbr) & ~dlab;
  assign dl_wr  = wr & dlab & ((addr == AddrRbr) | (addr == AddrIer));
  assign rbr_rd = rd & (addr == AddrRbr) & ~dlab;
  assign iir_rd = rd & (addr == AddrIir);
  assign lsr_rd = rd & (addr == AddrLsr);
  assign msr_rd = rd & (addr == AddrMsr);

`ifdef UART_LOOPBACK_EN
  assign loop       = mcr_q[4];
  assign msr_hi_cur = loop ? {mcr_q[3], mcr_q[2], mcr_q[0], mcr_q[1]}
                           : ~{dcd_pad_i, ri_pad_i, dsr_pad_i, cts_pad_i};
`else
  assign loop       = 1'b0;
  assign msr_hi_cur = ~{dcd_pad_i, ri_pad_i, dsr_pad_i, cts_pad_i};
`endif

  uart_baud_gen u_baud_gen (
    .clk_i     (clk),
    .rst_i     (rst),
    .divisor_i ({dlm_q, dll_q}),
    .reload_i  (dl_wr),
    .tick_o    (baud_o)
  );

  // Wishbone ack and host-written configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      ier_q <= '0;
      lcr_q <= 8'h03;
      mcr_q <= '0;
      scr_q <= '0;
      dll_q <= '0;
      dlm_q <= '0;
      thr_q <= '0;
    end else begin
      ack_q <= wb_cyc_i & wb_stb_i & ~ack_q;
      if (thr_wr) thr_q <= wdata;
      if (wr) begin
        case (addr)
          AddrRbr: if (dlab) dll_q <= wdata;
          AddrIer: begin
            if (dlab) dlm_q <= wdata;
            else      ier_q <= wdata[3:0];
          end
          AddrLcr: lcr_q <= wdata;
          AddrMcr: mcr_q <= wdata[4:0];
          AddrScr: scr_q <= wdata;
          default: ;
        endcase
      end
    end
  end

  // THRE and the THRE-interrupt pending flag; a new load beats a clear.
  always_comb begin
    thre_d = thre_q;
    if (tx_load) thre_d = 1'b1;
    if (thr_wr)  thre_d = 1'b0;
    thre_pend_d = thre_pend_q;
    if (thr_wr || (iir_rd && (iir_code == IirThre))) thre_pend_d = 1'b0;
    if (!thre_q && thre_d) thre_pend_d = 1'b1;
  end

  // Transmit frame sequencer: start, data LSB first, optional parity, stop(s).
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_par_d = tx_par_q;
    tx_out_d = tx_out_q;
    tx_load  = 1'b0;
    unique case (tx_st_q)
      StIdle: begin
        tx_out_d = 1'b1;
        if (!thre_q) begin
          tx_load  = 1'b1;
          tx_sh_d  = thr_q;
          tx_par_d = calc_parity(thr_q, lcr_q);
          tx_cnt_d = '0;
          tx_out_d = 1'b0;
          tx_st_d  = StStart;
        end
      end
      StStart: if (baud_o) begin
        tx_cnt_d = tx_cnt_q + 4'd1;
        if (tx_cnt_q == 4'd15) begin
          tx_st_d  = StData;
          tx_bit_d = '0;
          tx_out_d = tx_sh_q[0];
        end
      end
      StData: if (baud_o) begin
        tx_cnt_d = tx_cnt_q + 4'd1;
        if (tx_cnt_q == 4'd15) begin
          if (tx_bit_q == last_bit) begin
            if (lcr_q[LcrPen]) begin
              tx_st_d  = StParity;
              tx_out_d = tx_par_q;
            end else begin
              tx_st_d  = StStop;
              tx_bit_d = '0;
              tx_out_d = 1'b1;
            end
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = tx_sh_q >> 1;
            tx_out_d = tx_sh_q[1];
          end
        end
      end
      StParity: if (baud_o) begin
        tx_cnt_d = tx_cnt_q + 4'd1;
        if (tx_cnt_q == 4'd15) begin
          tx_st_d  = StStop;
          tx_bit_d = '0;
          tx_out_d = 1'b1;
        end
      end
      StStop: if (baud_o) begin
        tx_cnt_d = tx_cnt_q + 4'd1;
        if (tx_cnt_q == 4'd15) begin
          // tx_bit_q counts stop bits here
          if (lcr_q[LcrStb] && (tx_bit_q == 3'd0)) begin
            tx_bit_d = 3'd1;
          end else begin
            tx_st_d  = StIdle;
            tx_out_d = 1'b1;
          end
        end
      end
      default: tx_st_d = StIdle;
    endcase
  end

  // Receive frame sequencer: each bit is sampled on its 8th tick.
  always_comb begin
    rx_in    = loop ? tx_out_q : rx_s2_q;
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_par_d = rx_par_q;
    rx_done  = 1'b0;
    rx_pe    = 1'b0;
    rx_fe    = 1'b0;
    rx_bi    = 1'b0;
    unique case (rx_st_q)
      StIdle: begin
        if (rx_prev_q && !rx_in) begin
          rx_st_d  = StStart;
          rx_cnt_d = '0;
          rx_sh_d  = '0;
        end
      end
      StStart: if (baud_o) begin
        rx_cnt_d = rx_cnt_q + 4'd1;
        if ((rx_cnt_q == 4'd7) && rx_in) rx_st_d = StIdle;  // glitch, not a start bit
        if (rx_cnt_q == 4'd15) begin
          rx_st_d  = StData;
          rx_bit_d = '0;
        end
      end
      StData: if (baud_o) begin
        rx_cnt_d = rx_cnt_q + 4'd1;
        if (rx_cnt_q == 4'd7) rx_sh_d[rx_bit_q] = rx_in;
        if (rx_cnt_q == 4'd15) begin
          if (rx_bit_q == last_bit) begin
            rx_st_d = lcr_q[LcrPen] ? StParity : StStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      StParity: if (baud_o) begin
        rx_cnt_d = rx_cnt_q + 4'd1;
        if (rx_cnt_q == 4'd7)  rx_par_d = rx_in;
        if (rx_cnt_q == 4'd15) rx_st_d = StStop;
      end
      StStop: if (baud_o) begin
        rx_cnt_d = rx_cnt_q + 4'd1;
        if (rx_cnt_q == 4'd7) begin
          rx_done = 1'b1;
          rx_fe   = ~rx_in;
          rx_pe   = lcr_q[LcrPen] & (rx_par_q != calc_parity(rx_sh_q, lcr_q));
          rx_bi   = (rx_sh_q == 8'h00) & ~rx_in;
          rx_st_d = StIdle;
        end
      end
      default: rx_st_d = StIdle;
    endcase
  end

  // Frame state registers, RX synchronizer and THRE flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q     <= StIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      tx_par_q    <= 1'b0;
      tx_out_q    <= 1'b1;
      rx_st_q     <= StIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_par_q    <= 1'b0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      thre_q      <= 1'b1;
      thre_pend_q <= 1'b0;
    end else begin
      tx_st_q     <= tx_st_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      tx_par_q    <= tx_par_d;
      tx_out_q    <= tx_out_d;
      rx_st_q     <= rx_st_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_par_q    <= rx_par_d;
      rx_s1_q     <= srx_pad_i;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_in;
      thre_q      <= thre_d;
      thre_pend_q <= thre_pend_d;
    end
  end

  // Line status: host reads clear, a new byte in the same cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rbr_q <= '0;
      dr_q  <= 1'b0;
      oe_q  <= 1'b0;
      pe_q  <= 1'b0;
      fe_q  <= 1'b0;
      bi_q  <= 1'b0;
    end else begin
      if (rx_done) rbr_q <= rx_sh_q;
      if (rbr_rd) dr_q <= 1'b0;
      if (rx_done) dr_q <= 1'b1;
      if (lsr_rd) begin
        oe_q <= 1'b0;
        pe_q <= 1'b0;
        fe_q <= 1'b0;
        bi_q <= 1'b0;
      end
      if (rx_done && dr_q) oe_q <= 1'b1;
      if (rx_done && rx_pe) pe_q <= 1'b1;
      if (rx_done && rx_fe) fe_q <= 1'b1;
      if (rx_done && rx_bi) bi_q <= 1'b1;
    end
  end

  // Modem delta detection: DCTS/DDSR/DDCD on any change, TERI on RI trailing edge.
  assign msr_delta_set = {msr_hi_q[3] ^ msr_hi_cur[3],
                          msr_hi_q[2] & ~msr_hi_cur[2],
                          msr_hi_q[1] ^ msr_hi_cur[1],
                          msr_hi_q[0] ^ msr_hi_cur[0]};

  // Modem status registers; reset snapshots the pins so no stale deltas appear.
  always_ff @(posedge clk) begin
    if (rst) begin
      msr_hi_q    <= msr_hi_cur;
      msr_delta_q <= '0;
    end else begin
      msr_hi_q    <= msr_hi_cur;
      msr_delta_q <= (msr_rd ? 4'h0 : msr_delta_q) | msr_delta_set;
    end
  end

  assign lsr = {1'b0, thre_q & (tx_st_q == StIdle), thre_q, bi_q, fe_q, pe_q, oe_q, dr_q};

  // Interrupt priority encoder.
  always_comb begin
    iir_code = IirNone;
    if (ier_q[2] && (|lsr[LsrBi:LsrOe]))  iir_code = IirRls;
    else if (ier_q[0] && lsr[LsrDr])      iir_code = IirRda;
    else if (ier_q[1] && thre_pend_q)     iir_code = IirThre;
    else if (ier_q[3] && (|msr_delta_q))  iir_code = IirModem;
  end

  // Registered interrupt output.
  always_ff @(posedge clk) begin
    if (rst) int_q <= 1'b0;
    else     int_q <= ~iir_code[0];
  end

  // Read data mux, driven only during the ack cycle.
  always_comb begin
    rdata = 8'h00;
    case (addr)
      AddrRbr: rdata = dlab ? dll_q : rbr_q;
      AddrIer: rdata = dlab ? dlm_q : {4'h0, ier_q};
      AddrIir: rdata = {4'h0, iir_code};
      AddrLcr: rdata = lcr_q;
      AddrMcr: rdata = {3'b000, mcr_q};
      AddrLsr: rdata = lsr;
      AddrMsr: rdata = {msr_hi_q, msr_delta_q};
      AddrScr: rdata = scr_q;
      default: rdata = 8'h00;
    endcase
  end

  assign wb_dat_o  = ack_q ? DATA_WIDTH'(rdata) : '0;
  assign wb_ack_o  = ack_q;
  assign int_o     = int_q;
  assign stx_pad_o = loop ? 1'b1 : (lcr_q[LcrBreak] ? 1'b0 : tx_out_q);
  assign rts_pad_o = loop ? 1'b1 : ~mcr_q[1];
  assign dtr_pad_o = loop ? 1'b1 : ~mcr_q[0];

endmodule

// File: tb/tb_uart_wb_modport.sv
// tb_uart_wb_modport: directed self-checking bench for uart_wb_modport.
module tb_uart_wb_modport;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] adr = '0;
  logic [7:0] wdat = '0;
  logic [7:0] rdat;
  logic       we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic       ack, intr, srx = 1'b1, stx, rts, dtr, baud;
  logic       cts = 1'b1, dsr = 1'b1, ri = 1'b1, dcd = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_wb_modport #(
    .ADDR_WIDTH (3),
    .DATA_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_adr_i  (adr),
    .wb_dat_i  (wdat),
    .wb_dat_o  (rdat),
    .wb_we_i   (we),
    .wb_stb_i  (stb),
    .wb_cyc_i  (cyc),
    .wb_sel_i  (4'hF),
    .wb_ack_o  (ack),
    .int_o     (intr),
    .srx_pad_i (srx),
    .stx_pad_o (stx),
    .rts_pad_o (rts),
    .dtr_pad_o (dtr),
    .cts_pad_i (cts),
    .dsr_pad_i (dsr),
    .ri_pad_i  (ri),
    .dcd_pad_i (dcd),
    .baud_o    (baud)
  );

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One classic cycle; ack must rise within a bounded wait and last one cycle.
  task automatic wb_xfer(input logic [2:0] a, input logic w, input logic [7:0] d,
                         output logic [7:0] q);
    int n;
    @(negedge clk);
    adr = a; wdat = d; we = w; cyc = 1'b1; stb = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    check1("ack_high", ack, 1'b1);
    q = rdat;
    @(negedge clk);
    check1("ack_one_cycle", ack, 1'b0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb_xfer(a, 1'b1, d, q);
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] q;
    wb_xfer(a, 1'b0, 8'h00, q);
    check8(tag, q, exp);
  endtask

  // 8N1-style frame at 16 clocks per bit with a selectable stop level.
  task automatic send_byte(input logic [7:0] d, input logic stop_v);
    @(negedge clk);
    srx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      srx = d[i];
      repeat (16) @(negedge clk);
    end
    srx = stop_v;
    repeat (16) @(negedge clk);
    srx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [9:0] tx_exp;
    int         n;

    repeat (4) @(negedge clk);
    check1("reset_stx", stx, 1'b1);
    check1("reset_rts", rts, 1'b1);
    check1("reset_dtr", dtr, 1'b1);
    check1("reset_int", intr, 1'b0);
    check1("reset_baud", baud, 1'b0);
    rst = 1'b0;

    // Reset values of all eight registers
    rd_check("rst_rbr", 3'd0, 8'h00);
    rd_check("rst_ier", 3'd1, 8'h00);
    rd_check("rst_iir", 3'd2, 8'h01);
    rd_check("rst_lcr", 3'd3, 8'h03);
    rd_check("rst_mcr", 3'd4, 8'h00);
    rd_check("rst_lsr", 3'd5, 8'h60);
    rd_check("rst_msr", 3'd6, 8'h00);
    rd_check("rst_scr", 3'd7, 8'h00);

    wb_write(3'd7, 8'h5A);
    rd_check("scr_rw", 3'd7, 8'h5A);

    // Divisor = 1, 8N1
    wb_write(3'd3, 8'h80);
    wb_write(3'd0, 8'h01);
    wb_write(3'd1, 8'h00);
    rd_check("dll_rb", 3'd0, 8'h01);
    wb_write(3'd3, 8'h03);
    check1("baud_tick_dl1", baud, 1'b1);

    // Transmit 0xA5
    tx_exp = {1'b1, 8'hA5, 1'b0};
    wb_write(3'd0, 8'hA5);
    n = 0;
    while (stx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check1("tx_start_seen", stx, 1'b0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check1($sformatf("tx_bit%0d", i), stx, tx_exp[i]);
      repeat (16) @(negedge clk);
    end
    rd_check("tx_lsr_done", 3'd5, 8'h60);

    // Receive 0x3C
    send_byte(8'h3C, 1'b1);
    rd_check("rx_lsr_dr", 3'd5, 8'h61);
    rd_check("rx_rbr", 3'd0, 8'h3C);
    rd_check("rx_lsr_clr", 3'd5, 8'h60);

    // Overrun
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rd_check("oe_lsr", 3'd5, 8'h63);
    rd_check("oe_lsr_clr", 3'd5, 8'h61);
    rd_check("oe_rbr", 3'd0, 8'h22);
    rd_check("oe_lsr_empty", 3'd5, 8'h60);

    // Interrupt priority: framing error plus data ready
    wb_write(3'd1, 8'h07);
    send_byte(8'h55, 1'b0);
    rd_check("iir_rls", 3'd2, 8'h06);
    check1("int_rls", intr, 1'b1);
    rd_check("fe_lsr", 3'd5, 8'h69);
    rd_check("iir_rda", 3'd2, 8'h04);
    check1("int_rda", intr, 1'b1);
    rd_check("fe_rbr", 3'd0, 8'h55);
    rd_check("iir_thre", 3'd2, 8'h02);
    rd_check("iir_none", 3'd2, 8'h01);
    repeat (2) @(negedge clk);
    check1("int_clear", intr, 1'b0);

    // Modem outputs and status
    wb_write(3'd4, 8'h03);
    check1("rts_on", rts, 1'b0);
    check1("dtr_on", dtr, 1'b0);
    wb_write(3'd4, 8'h00);
    check1("rts_off", rts, 1'b1);
    wb_write(3'd1, 8'h08);
    cts = 1'b0;
    repeat (4) @(negedge clk);
    check1("int_modem", intr, 1'b1);
    rd_check("msr_dcts", 3'd6, 8'h11);
    repeat (2) @(negedge clk);
    check1("int_modem_clr", intr, 1'b0);
    rd_check("msr_after", 3'd6, 8'h10);

    // Reset in the middle of a transmitted frame
    wb_write(3'd1, 8'h00);
    wb_write(3'd0, 8'h0F);
    n = 0;
    while (stx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check1("tx2_start_seen", stx, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check1("rst_abort_stx", stx, 1'b1);
    rst = 1'b0;
    rd_check("rst_abort_lsr", 3'd5, 8'h60);
    rd_check("rst_abort_lcr", 3'd3, 8'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
